// File: rtl/event_blinker_if.sv
// event_blinker_if: event strobe in, blink/queue status out for one LED indicator
// Signals: trig (event strobe), led (blink output), busy (blink in progress),
//          pending (queued events), dropped (event lost on full queue)
interface event_blinker_if #(parameter int PEND_W = 3);
   logic              trig;
   logic              led;
   logic              busy;
   logic [PEND_W-1:0] pending;
   logic              dropped;
   modport master (output trig, input led, busy, pending, dropped);
   modport slave (input trig, output led, busy, pending, dropped);
endinterface

// File: rtl/event_blinker.sv
// event_blinker: turns one-cycle event strobes into LED blinks with minimum on/off times
// Ports: clk (clock), rst (async active-low reset),
//        bus (slave: trig in; led, busy, pending, dropped out)
module event_blinker #(
   parameter int ON_CYCLES  = 5_000_000,
   parameter int OFF_CYCLES = 5_000_000,
   parameter int PEND_W     = 3
) (
   input logic           clk,
   input logic           rst,
   event_blinker_if.slave bus
);
   localparam int CW = $clog2((ON_CYCLES > OFF_CYCLES ? ON_CYCLES : OFF_CYCLES) + 1);
   localparam logic [CW-1:0] ON_LD = CW'(ON_CYCLES - 1);
   localparam logic [CW-1:0] OFF_LD = CW'(OFF_CYCLES - 1);
   localparam logic [PEND_W-1:0] PMAX = '1;
   typedef enum logic [1:0] {IDLE, ON, OFF} state_t;
   state_t            state, state_d;
   logic [CW-1:0]     cnt, cnt_d;
   logic [PEND_W-1:0] pend, pend_d;
   logic              led_q, busy_q, drop_q;
   logic              led_d, busy_d, drop_d;
   logic              done, exit_off, inc;
   assign done = cnt == '0;
   assign exit_off = state == OFF && done;
   // a trig on the OFF exit edge is never queued: it either starts the next
   // blink directly or cancels against the pending decrement
   assign inc = bus.trig && state != IDLE && !exit_off;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         cnt    <= '0;
         pend   <= '0;
         led_q  <= 1'b0;
         busy_q <= 1'b0;
         drop_q <= 1'b0;
      end else begin
         state  <= state_d;
         cnt    <= cnt_d;
         pend   <= pend_d;
         led_q  <= led_d;
         busy_q <= busy_d;
         drop_q <= drop_d;
      end
   end
   always_comb begin
      state_d = state;
      cnt_d = cnt;
      case (state)
         IDLE: begin
            state_d = bus.trig ? ON : IDLE;
            cnt_d = bus.trig ? ON_LD : cnt;
         end
         ON: begin
            state_d = done ? OFF : ON;
            cnt_d = done ? OFF_LD : cnt - 1'b1;
         end
         OFF: begin
            state_d = !done ? OFF : (pend != '0 || bus.trig) ? ON : IDLE;
            cnt_d = !done ? cnt - 1'b1 : ON_LD;
         end
         default: state_d = IDLE;
      endcase
      pend_d = (exit_off && pend != '0 && !bus.trig) ? pend - 1'b1 :
               (inc && pend != PMAX) ? pend + 1'b1 : pend;
   end
   always_comb begin
      led_d = state_d == ON;
      busy_d = state_d != IDLE;
      drop_d = inc && pend == PMAX;
   end
   assign bus.led = led_q;
   assign bus.busy = busy_q;
   assign bus.pending = pend;
   assign bus.dropped = drop_q;
endmodule

// File: tb/tb_event_blinker.sv
// tb_event_blinker: directed checks of blink timing, queueing, saturation and reset
module tb_event_blinker;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int checks = 0;
   int errors = 0;
   int edge_n = 0;
   logic [63:0] tm, lm, bm, dm;
   logic [1:0] pexp [0:63];
   event_blinker_if #(.PEND_W(2)) bus ();
   event_blinker #(.ON_CYCLES(4), .OFF_CYCLES(3), .PEND_W(2)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   always #5 clk = ~clk;
   function automatic logic [63:0] rng(input int a, input int b);
      logic [63:0] m;
      m = '0;
      for (int i = a; i <= b; i++) m[i] = 1'b1;
      return m;
   endfunction
   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s edge %0d observed %0h expected %0h", tag, edge_n, obs, exp);
      end
   endtask
   task automatic clr();
      tm = '0;
      lm = '0;
      bm = '0;
      dm = '0;
      for (int i = 0; i < 64; i++) pexp[i] = 2'd0;
   endtask
   task automatic pset(input int a, input int b, input logic [1:0] v);
      for (int i = a; i <= b; i++) pexp[i] = v;
   endtask
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      bus.trig = 1'b0;
      #1;
      chk("rst_led", {3'b0, bus.led}, 4'd0);
      chk("rst_busy", {3'b0, bus.busy}, 4'd0);
      chk("rst_pend", {2'b0, bus.pending}, 4'd0);
      chk("rst_drop", {3'b0, bus.dropped}, 4'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      edge_n = 0;
   endtask
   task automatic run(input int last);
      for (int e = 1; e <= last; e++) begin
         bus.trig = tm[e];
         @(posedge clk);
         #1;
         edge_n = e;
         chk("led", {3'b0, bus.led}, {3'b0, lm[e]});
         chk("busy", {3'b0, bus.busy}, {3'b0, bm[e]});
         chk("pending", {2'b0, bus.pending}, {2'b0, pexp[e]});
         chk("dropped", {3'b0, bus.dropped}, {3'b0, dm[e]});
         @(negedge clk);
      end
      bus.trig = 1'b0;
   endtask
   initial begin
      bus.trig = 1'b0;
      // reset values held while idle
      clr();
      do_reset();
      run(20);
      // single event
      clr();
      tm = rng(10, 10);
      lm = rng(10, 13);
      bm = rng(10, 16);
      do_reset();
      run(25);
      // three queued events
      clr();
      tm = rng(10, 12);
      lm = rng(10, 13) | rng(17, 20) | rng(24, 27);
      bm = rng(10, 30);
      pset(11, 11, 2'd1);
      pset(12, 16, 2'd2);
      pset(17, 23, 2'd1);
      do_reset();
      run(36);
      // saturation and drop
      clr();
      tm = rng(10, 14);
      lm = rng(10, 13) | rng(17, 20) | rng(24, 27) | rng(31, 34);
      bm = rng(10, 37);
      dm = rng(14, 14);
      pset(11, 11, 2'd1);
      pset(12, 12, 2'd2);
      pset(13, 16, 2'd3);
      pset(17, 23, 2'd2);
      pset(24, 30, 2'd1);
      do_reset();
      run(45);
      // trig on the OFF exit edge with one queued event cancels the decrement
      clr();
      tm = rng(10, 11) | rng(17, 17);
      lm = rng(10, 13) | rng(17, 20) | rng(24, 27);
      bm = rng(10, 30);
      pset(11, 23, 2'd1);
      do_reset();
      run(36);
      // trig on the OFF exit edge with empty queue chains a blink directly
      clr();
      tm = rng(10, 10) | rng(17, 17);
      lm = rng(10, 13) | rng(17, 20);
      bm = rng(10, 23);
      do_reset();
      run(30);
      // reset asserted mid-blink clears outputs without a clock edge
      clr();
      tm = rng(10, 11);
      lm = rng(10, 12);
      bm = rng(10, 12);
      pset(11, 12, 2'd1);
      do_reset();
      run(12);
      rst = 1'b0;
      #1;
      chk("async_led", {3'b0, bus.led}, 4'd0);
      chk("async_busy", {3'b0, bus.busy}, 4'd0);
      chk("async_pend", {2'b0, bus.pending}, 4'd0);
      clr();
      tm = rng(20, 20);
      lm = rng(20, 23);
      bm = rng(20, 26);
      do_reset();
      run(32);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/event_blinker.md
# event_blinker

Converts single-cycle event pulses (e.g. debounced button `raised` strobes, MIDI note-on strobes) into human-visible LED blinks with guaranteed minimum on-time and off-gap. Every accepted event yields exactly one blink. Events arriving while a blink is in progress are queued in a saturating pending counter. Sits between event sources and board LED pins; one instance per indicator.

## Interface

- `ON_CYCLES`, default 5_000_000: LED high time per blink, in clk cycles (50 ms at 100 MHz); must be ≥1.
- `OFF_CYCLES`, default 5_000_000: minimum LED low gap after each blink, in clk cycles; must be ≥1.
- `PEND_W`, default 3: pending counter width; queue depth = 2^PEND_W − 1.

- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `trig`  in  1  event strobe; each high clk cycle is one event; synchronous to `clk`.
- `led`  out  1  blink output, registered.
- `busy`  out  1  high whenever state ≠ IDLE, registered.
- `pending`  out  PEND_W  queued events not yet blinked.
- `dropped`  out  1  one-cycle pulse; an event was lost because `pending` was saturated.

## Operation

- States: IDLE, ON, OFF. A single down-counter or up-counter, width `$clog2(max(ON_CYCLES, OFF_CYCLES)+1)`, times both ON and OFF.
- IDLE: `led`=0, `busy`=0, `pending`=0 (invariant). `trig` → ON, counter reloaded.
- ON: `led`=1. After exactly ON_CYCLES cycles → OFF, counter reloaded.
- OFF: `led`=0. After exactly OFF_CYCLES cycles:
  - `pending`>0 → ON, `pending` decremented.
  - else, `trig` high on that edge → ON; `pending` stays 0.
  - else → IDLE.
- `trig` in ON or OFF, except on the OFF exit edge: `pending` increments, saturating at 2^PEND_W−1.
  - If already saturated, `pending` holds and `dropped` pulses for one cycle.
- Simultaneous `trig` and decrement on the OFF exit edge with `pending`>0: increment and decrement cancel. `pending` is unchanged, and next state is ON.
- Arithmetic is unsigned. `pending` never wraps, in either direction.

## Timing

- Reset (async assert): `led`=0, `busy`=0, `pending`=0, `dropped`=0, state IDLE, counter 0. This takes effect immediately, without a clock edge, including mid-blink.
- Reset deassert: the first `trig` sampled is on the first rising edge with `rst` high.
- Latency: `trig` sampled at edge E in IDLE → `led` and `busy` rise after edge E.
  - `led` falls after edge E+ON_CYCLES.
  - At edge E+ON_CYCLES+OFF_CYCLES, the block returns to IDLE (`busy` falls) or starts the next blink.
- Back-to-back blinks have a period of exactly ON_CYCLES+OFF_CYCLES, with no idle cycle inserted.
- `dropped` is asserted in the cycle after the edge that sampled the lost `trig`.
- `pending` and `busy` are updated on the same edge as the state change.

## Test plan

Parameters for all scenarios: ON_CYCLES=4, OFF_CYCLES=3, PEND_W=2. Edges are numbered from the first edge after reset release.

- **Reset values:** assert `rst`=0, then release it with `trig`=0 → `led`, `busy`, `pending`, `dropped` all 0 for 20 cycles.
- **Single event:** `trig` at edge 10 →
  - `led` high after edges 10–13, low from edge 14.
  - `busy` high after edges 10–16, low from edge 17.
  - `pending` stays 0.
- **Queued events:** `trig` at edges 10, 11, 12 →
  - `pending` reads 1, 2 after edges 11, 12.
  - Blinks rise at edges 10, 17, 24, each lasting 4 cycles.
  - `pending` reads 1 after edge 17 and 0 after edge 24.
  - `busy` falls at edge 31.
- **Saturation:** `trig` at edges 10–14 →
  - `pending` reaches 3 at edge 13.
  - `trig` at edge 14 gives a `dropped` pulse for one cycle; `pending` stays 3.
  - Exactly 4 blinks follow.
- **Simultaneous events:**
  - `trig` at edges 10 and 11, plus `trig` at edge 17 → `pending` remains 1 after edge 17, the second blink rises at edge 17, and a third blink rises at 24.
  - With only a single `trig` at 10 plus `trig` at 17 → the second blink rises at 17 with no IDLE cycle.
- **Reset mid-operation:**
  - `trig` at edges 10 and 11; drop `rst` at cycle 12.5 → `led`, `busy`, `pending` go 0 immediately.
  - Release `rst`, then `trig` at edge 20 → a normal 4-cycle blink.
